// File: rtl/mod_pkg.sv
// Shared definitions for the modulo scheduler.
//   WIDTH_DEFAULT : default operand/result width in bits
//   state_e       : scheduler FSM states (idle, iterating, result held)
package mod_pkg;

    localparam int unsigned WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/mod_step.sv
// One restoring shift-subtract step of an unsigned divider (purely combinational).
// Ports:
//   rem_in       : partial remainder before the step (WIDTH+1 bits)
//   divisor      : divisor B
//   dividend_bit : next dividend bit, MSB first
//   rem_out      : partial remainder after the step
//   quo_bit      : quotient bit produced by this step
module mod_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dividend_bit,
    output logic [WIDTH:0]   rem_out,
    output logic             quo_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    // The remainder is always below the divisor, so its top bit is never set on entry.
    logic           unused_msb;

    assign unused_msb = rem_in[WIDTH];

    always_comb begin
        shifted = {rem_in[WIDTH-1:0], dividend_bit};
        diff    = shifted - {1'b0, divisor};
        quo_bit = (shifted >= {1'b0, divisor});
        rem_out = quo_bit ? diff : shifted;
    end

endmodule

// File: rtl/mod_scheduler.sv
// Two-requester scheduler around one shared iterative A mod B datapath.
// Optional feature: define MOD_SCHED_QUOTIENT_EN to add the quotient register and port Heres.
// Ports:
//   Clock, Reset              : rising-edge clock, synchronous active-high reset
//   Kerkesa<n>_valid/_ready   : request handshake of requester n (ready only on grant)
//   Hyrja1_<n>, Hyrja2_<n>    : dividend A and divisor B of requester n
//   Dalja, Dalja_id           : remainder and owning requester index
//   Dalja_valid, Dalja_ready  : result handshake
//   Gabim                     : divide-by-zero flag, qualified by Dalja_valid
//   Heres                     : quotient (only with MOD_SCHED_QUOTIENT_EN)
module mod_scheduler
    import mod_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Kerkesa0_valid,
    input  logic             Kerkesa1_valid,
    output logic             Kerkesa0_ready,
    output logic             Kerkesa1_ready,
    input  logic [WIDTH-1:0] Hyrja1_0,
    input  logic [WIDTH-1:0] Hyrja2_0,
    input  logic [WIDTH-1:0] Hyrja1_1,
    input  logic [WIDTH-1:0] Hyrja2_1,
    output logic [WIDTH-1:0] Dalja,
    output logic             Dalja_id,
    output logic             Dalja_valid,
    input  logic             Dalja_ready,
    output logic             Gabim
`ifdef MOD_SCHED_QUOTIENT_EN
    ,
    output logic [WIDTH-1:0] Heres
`endif
);

    localparam logic [WIDTH-1:0] LastStep = WIDTH'(WIDTH - 1);

    state_e           state_q, state_d;
    logic             ptr_q;
    logic             id_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] dalja_q;
    logic             gabim_q;
`ifdef MOD_SCHED_QUOTIENT_EN
    logic [WIDTH-1:0] quo_q;
`endif

    logic             any_req;
    logic             grant_id;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH:0]   rem_next;
    logic             quo_bit;

    mod_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_in      (rem_q),
        .divisor     (b_q),
        .dividend_bit(a_q[WIDTH-1]),
        .rem_out     (rem_next),
        .quo_bit     (quo_bit)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        Kerkesa0_ready = 1'b0;
        Kerkesa1_ready = 1'b0;
        any_req        = Kerkesa0_valid | Kerkesa1_valid;
        // The pointer only breaks ties; a lone requester always wins.
        grant_id       = (Kerkesa0_valid & Kerkesa1_valid) ? ptr_q : Kerkesa1_valid;
        sel_a          = grant_id ? Hyrja1_1 : Hyrja1_0;
        sel_b          = grant_id ? Hyrja2_1 : Hyrja2_0;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    Kerkesa0_ready = ~grant_id;
                    Kerkesa1_ready = grant_id;
                    state_d        = (sel_b == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (cnt_q == LastStep) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (Dalja_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            dalja_q <= '0;
            gabim_q <= 1'b0;
`ifdef MOD_SCHED_QUOTIENT_EN
            quo_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        ptr_q <= ~grant_id;
                        id_q  <= grant_id;
                        a_q   <= sel_a;
                        b_q   <= sel_b;
                        rem_q <= '0;
                        cnt_q <= '0;
                        // Division by zero skips the iteration and reports A unchanged.
                        if (sel_b == '0) begin
                            dalja_q <= sel_a;
                            gabim_q <= 1'b1;
`ifdef MOD_SCHED_QUOTIENT_EN
                            quo_q   <= '1;
`endif
                        end else begin
                            gabim_q <= 1'b0;
`ifdef MOD_SCHED_QUOTIENT_EN
                            quo_q   <= '0;
`endif
                        end
                    end
                end
                StRun: begin
                    rem_q <= rem_next;
                    a_q   <= {a_q[WIDTH-2:0], 1'b0};
                    cnt_q <= cnt_q + 1'b1;
`ifdef MOD_SCHED_QUOTIENT_EN
                    quo_q <= {quo_q[WIDTH-2:0], quo_bit};
`endif
                    if (cnt_q == LastStep) begin
                        dalja_q <= rem_next[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef MOD_SCHED_QUOTIENT_EN
    logic unused_quo_bit;
    assign unused_quo_bit = quo_bit;
`endif

    assign Dalja       = dalja_q;
    assign Dalja_id    = id_q;
    assign Dalja_valid = (state_q == StDone);
    assign Gabim       = gabim_q;
`ifdef MOD_SCHED_QUOTIENT_EN
    assign Heres       = quo_q;
`endif

endmodule

// File: tb/tb_mod_scheduler.sv
// Self-checking bench for mod_scheduler: directed scenarios followed by randomized traffic,
// compared against a behavioural model (round-robin pointer plus plain % and /).
// Optional feature: MOD_SCHED_QUOTIENT_EN adds quotient checks on Heres.
module tb_mod_scheduler;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          k0v, k1v;
    logic          k0r, k1r;
    logic [W-1:0]  a0, b0, a1, b1;
    logic [W-1:0]  dalja;
    logic          did, dv, dr, gab;
`ifdef MOD_SCHED_QUOTIENT_EN
    logic [W-1:0]  heres;
`endif

    int            errors = 0;
    int            checks = 0;
    logic          ptr_m;

    always #5 clk = ~clk;

    mod_scheduler #(
        .WIDTH(W)
    ) dut (
        .Clock         (clk),
        .Reset         (rst),
        .Kerkesa0_valid(k0v),
        .Kerkesa1_valid(k1v),
        .Kerkesa0_ready(k0r),
        .Kerkesa1_ready(k1r),
        .Hyrja1_0      (a0),
        .Hyrja2_0      (b0),
        .Hyrja1_1      (a1),
        .Hyrja2_1      (b1),
        .Dalja         (dalja),
        .Dalja_id      (did),
        .Dalja_valid   (dv),
        .Dalja_ready   (dr),
        .Gabim         (gab)
`ifdef MOD_SCHED_QUOTIENT_EN
        ,
        .Heres         (heres)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_b();
        case ($urandom_range(0, 4))
            0:       return 16'd0;
            1:       return 16'd1;
            2:       return 16'($urandom_range(2, 20));
            default: return 16'($urandom);
        endcase
    endfunction

    // Called with requests already driven; serves exactly one operation end to end.
    task automatic serve(input string tag, input int stall);
        logic         exp_id;
        logic [W-1:0] ea, eb, em, eq;
        int           lat;
        logic         busy_bad;
        exp_id = (k0v && k1v) ? ptr_m : k1v;
        ea     = exp_id ? a1 : a0;
        eb     = exp_id ? b1 : b0;
        em     = (eb == 0) ? ea : ea % eb;
        eq     = (eb == 0) ? 16'hffff : ea / eb;
        #1;
        chk({tag, "/ready0"}, 32'(k0r), 32'(exp_id == 1'b0));
        chk({tag, "/ready1"}, 32'(k1r), 32'(exp_id == 1'b1));
        ptr_m    = ~exp_id;
        lat      = 0;
        busy_bad = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                if (exp_id) k1v = 1'b0;
                else        k0v = 1'b0;
            end
            #1;
            if (k0r || k1r) busy_bad = 1'b1;
        end while (!dv && lat < 40);
        chk({tag, "/latency"}, 32'(lat), (eb == 0) ? 32'd1 : 32'(W + 1));
        chk({tag, "/ready_while_busy"}, 32'(busy_bad), 32'd0);
        chk({tag, "/dalja"}, 32'(dalja), 32'(em));
        chk({tag, "/id"}, 32'(did), 32'(exp_id));
        chk({tag, "/gabim"}, 32'(gab), 32'(eb == 0));
`ifdef MOD_SCHED_QUOTIENT_EN
        chk({tag, "/heres"}, 32'(heres), 32'(eq));
`endif
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            #1;
            chk({tag, "/stall_valid"}, 32'(dv), 32'd1);
            chk({tag, "/stall_dalja"}, 32'(dalja), 32'(em));
            chk({tag, "/stall_id"}, 32'(did), 32'(exp_id));
            chk({tag, "/stall_gabim"}, 32'(gab), 32'(eb == 0));
            chk({tag, "/stall_ready"}, 32'({k0r, k1r}), 32'd0);
`ifdef MOD_SCHED_QUOTIENT_EN
            chk({tag, "/stall_heres"}, 32'(heres), 32'(eq));
`endif
        end
        dr = 1'b1;
        @(negedge clk);
        dr = 1'b0;
        #1;
        chk({tag, "/released"}, 32'(dv), 32'd0);
    endtask

    initial begin
        logic seen_valid;
        rst   = 1'b1;
        k0v   = 1'b0;
        k1v   = 1'b0;
        dr    = 1'b0;
        a0    = '0;
        b0    = '0;
        a1    = '0;
        b1    = '0;
        ptr_m = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset/valid", 32'(dv), 32'd0);
        chk("reset/dalja", 32'(dalja), 32'd0);
        chk("reset/id", 32'(did), 32'd0);
        chk("reset/gabim", 32'(gab), 32'd0);
        chk("reset/ready", 32'({k0r, k1r}), 32'd0);
`ifdef MOD_SCHED_QUOTIENT_EN
        chk("reset/heres", 32'(heres), 32'd0);
`endif
        rst = 1'b0;

        // Both requesters valid in the first cycle after reset.
        a0 = 16'd65535; b0 = 16'd65535; a1 = 16'd10; b1 = 16'd3;
        k0v = 1'b1; k1v = 1'b1;
        serve("tie_first", 0);
        serve("tie_second", 0);

        // 100 mod 7 with a stalled consumer, then 1234 mod 0 held off behind it.
        a0 = 16'd100; b0 = 16'd7; a1 = 16'd1234; b1 = 16'd0;
        k0v = 1'b1; k1v = 1'b1;
        serve("mod100_7", 5);
        serve("div_zero", 0);

        // Reset during the 8th RUN cycle aborts the operation.
        a0 = 16'd50000; b0 = 16'd3; k0v = 1'b1;
        #1;
        chk("abort/grant", 32'(k0r), 32'd1);
        @(negedge clk);
        k0v = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("abort/valid", 32'(dv), 32'd0);
        chk("abort/dalja", 32'(dalja), 32'd0);
        chk("abort/id", 32'(did), 32'd0);
        chk("abort/gabim", 32'(gab), 32'd0);
        chk("abort/ready", 32'({k0r, k1r}), 32'd0);
`ifdef MOD_SCHED_QUOTIENT_EN
        chk("abort/heres", 32'(heres), 32'd0);
`endif
        rst   = 1'b0;
        ptr_m = 1'b0;
        seen_valid = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (dv) seen_valid = 1'b1;
        end
        chk("abort/no_result", 32'(seen_valid), 32'd0);

        // Pointer must be back at requester 0 after reset.
        a0 = 16'd999; b0 = 16'd1; a1 = 16'd5; b1 = 16'd9;
        k0v = 1'b1; k1v = 1'b1;
        serve("post_reset0", 0);
        serve("post_reset1", 0);

        for (int i = 0; i < 30; i++) begin
            if (!k0v && $urandom_range(0, 1) == 1) begin
                a0 = 16'($urandom); b0 = rnd_b(); k0v = 1'b1;
            end
            if (!k1v && $urandom_range(0, 1) == 1) begin
                a1 = 16'($urandom); b1 = rnd_b(); k1v = 1'b1;
            end
            if (!k0v && !k1v) begin
                a0 = 16'($urandom); b0 = rnd_b(); k0v = 1'b1;
            end
            serve("random", $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mod_scheduler.md
MOD_SCHEDULER -- requirements
Module: mod_scheduler

Interface
REQ-001 Parameter SHALL be: WIDTH, 16, operand/result width in bits.
REQ-002 Port SHALL be: Clock  in  1  sole clock, rising edge.
REQ-003 Port SHALL be: Reset  in  1  synchronous, active-high reset.
REQ-004 Ports SHALL be, for n = 0,1: Kerkesa<n>_valid  in  1  requester n has an operation pending.
REQ-005 Ports SHALL be, for n = 0,1: Kerkesa<n>_ready  out  1  requester n operands accepted this cycle.
REQ-006 Ports SHALL be, for n = 0,1: Hyrja1_<n>  in  WIDTH  dividend A of requester n.
REQ-007 Ports SHALL be, for n = 0,1: Hyrja2_<n>  in  WIDTH  divisor B of requester n.
REQ-008 Port SHALL be: Dalja  out  WIDTH  A mod B.
REQ-009 Port SHALL be: Dalja_id  out  1  index of the requester owning Dalja.
REQ-010 Port SHALL be: Dalja_valid  out  1  result available.
REQ-011 Port SHALL be: Dalja_ready  in  1  consumer accepts the result.
REQ-012 Port SHALL be: Gabim  out  1  divide-by-zero flag, qualified by Dalja_valid.
REQ-013 Port SHALL be: Heres  out  WIDTH  quotient A/B; present only with MOD_SCHED_QUOTIENT_EN.

Function
REQ-014 Block SHALL share one iterative modulo datapath between two requesters through FSM states IDLE, RUN and DONE.
REQ-015 In IDLE with at least one Kerkesa<n>_valid, block SHALL grant one requester, assert only its Kerkesa<n>_ready combinationally, capture its operands and id, and leave IDLE at the next edge.
REQ-016 Arbitration SHALL be round-robin: if both are valid, the requester indicated by the priority pointer wins; after each grant the pointer SHALL point to the other requester.
REQ-017 Both Kerkesa<n>_ready SHALL be 0 in RUN and DONE; requests SHALL be held off, not dropped.
REQ-018 If captured B = 0, FSM SHALL go IDLE->DONE with Dalja = A, Gabim = 1, and Heres = all ones.
REQ-019 Otherwise, RUN SHALL perform exactly WIDTH restoring shift-subtract steps (MSB first, WIDTH-bit step counter, WIDTH+1-bit partial remainder) and then enter DONE.
REQ-020 Dalja_valid SHALL rise WIDTH+1 cycles after the grant cycle (1 cycle when B = 0).
REQ-021 In DONE, Dalja_valid SHALL be 1, and Dalja, Dalja_id, Gabim and Heres SHALL stay stable until a cycle with Dalja_ready = 1; FSM SHALL then return to IDLE.
REQ-022 A new grant SHALL occur no earlier than the cycle after the handshake (no bypass).
REQ-023 Boundary results SHALL be: A < B gives Dalja = A and Heres = 0; B = 1 gives Dalja = 0 and Heres = A.

Reset
REQ-024 Reset SHALL force IDLE, priority pointer = 0, and Dalja, Dalja_id, Dalja_valid, Gabim, Heres and counter = 0, including when asserted mid-RUN or mid-DONE; an aborted operation SHALL produce no result.

Configuration
REQ-025 With MOD_SCHED_QUOTIENT_EN defined, port Heres and the quotient register SHALL exist; without it, both SHALL be absent and the remainder behaviour SHALL be unchanged.

Structure
REQ-026 The state encoding and the WIDTH default SHALL be defined in the shared package mod_pkg.
REQ-027 One shift-subtract step SHALL be implemented in sub-module mod_step (combinational; partial remainder, divisor and dividend bit in; next remainder and quotient bit out).

Verification
REQ-028 Bench SHALL cover: requester 0 sends A = 100, B = 7 -> Dalja = 2, Dalja_id = 0, Gabim = 0, Dalja_valid 17 cycles after grant.
REQ-029 Bench SHALL cover: both requesters valid in the first cycle after reset (req0 65535 mod 65535, req1 10 mod 3) -> req0 served first with result 0, then req1 with result 1.
REQ-030 Bench SHALL cover: A = 1234, B = 0 -> Dalja = 1234 and Gabim = 1 one cycle after grant.
REQ-031 Bench SHALL cover: Dalja_ready held 0 for 5 cycles in DONE -> outputs stable, both Kerkesa<n>_ready = 0 throughout.
REQ-032 Bench SHALL cover: Reset asserted at the 8th RUN cycle -> next cycle all outputs 0, FSM in IDLE, and no result is delivered.
REQ-033 Bench SHALL cover, with MOD_SCHED_QUOTIENT_EN defined: A = 100, B = 7 -> Heres = 14.
